// File: rtl/skc_pkg.sv
// Shared definitions for the bit-serial key checker.
//   skc_state_e    : checker FSM states
//   SKC_LFSR_TAPS  : feedback mask for the 16-bit keystream LFSR (taps 16,14,13,11)
//   SKC_KEY_W_DEF  : default key width
//   skc_lfsr_next  : one LFSR step (shift right, feedback into bit 15)
package skc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } skc_state_e;

    // Tap n of the polynomial corresponds to bit 16-n of the right-shifting register.
    localparam logic [15:0] SKC_LFSR_TAPS = 16'h002D;
    localparam int          SKC_KEY_W_DEF = 16;

    function automatic logic [15:0] skc_lfsr_next(input logic [15:0] s);
        return {^(s & SKC_LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/skc_lfsr.sv
// Keystream generator: 16-bit Fibonacci LFSR, output bit is q[0].
// Ports:
//   C     in   clock, rising edge
//   R     in   synchronous active-high reset, loads seed
//   load  in   reload seed (start of a new check)
//   step  in   advance one position (a key bit was accepted)
//   seed  in   reload value
//   q     out  current register contents
module skc_lfsr
    import skc_pkg::*;
(
    input  logic        C,
    input  logic        R,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;

    always_ff @(posedge C) begin
        if (R || load) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= skc_lfsr_next(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/serial_key_checker.sv
// Bit-serial key checker. After start, accepts one bit per in_valid&in_ready
// handshake (bit 0 first), compares against KEY and reports done/ok once
// KEY_W bits have been taken. done/ok hold until the next start or R.
// Optional feature macro: SKC_KEYSTREAM_EN -- expected bits are KEY xor an
// LFSR keystream seeded with LFSR_SEED; without it no LFSR flops exist.
// Ports:
//   C          in   clock, rising edge
//   R          in   synchronous active-high reset
//   start      in   begin a new check (ignored while busy)
//   in_valid   in   in_bit valid this cycle
//   in_bit     in   key bit
//   in_ready   out  bit accepted this cycle if in_valid
//   bit_count  out  bits accepted in current check
//   done       out  check complete
//   ok         out  all bits matched (valid while done)
module serial_key_checker
    import skc_pkg::*;
#(
    parameter int               KEY_W     = SKC_KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY       = 16'hD1CE,
    parameter logic [15:0]      LFSR_SEED = 16'hACE1
) (
    input  logic                       C,
    input  logic                       R,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       in_ready,
    output logic [$clog2(KEY_W+1)-1:0] bit_count,
    output logic                       done,
    output logic                       ok
);

    localparam int CW = $clog2(KEY_W+1);

    skc_state_e       state_q;
    logic [CW-1:0]    bit_count_q;
    logic [CW-1:0]    bit_count_d;
    logic             mismatch_q;
    logic             done_q;
    logic             ok_q;

    logic             accept;
    logic             last;
    logic             start_take;
    logic             exp_bit;
    logic             bit_mis;
    logic [KEY_W-1:0] key_sh;

    assign in_ready    = (state_q == BUSY);
    assign accept      = in_valid & in_ready;
    assign last        = (bit_count_q == CW'(KEY_W-1));
    assign start_take  = start & (state_q != BUSY);
    assign bit_count_d = bit_count_q + CW'(1);

    // Shift instead of indexing so the count width need not match the key index width.
    assign key_sh = KEY >> bit_count_q;

`ifdef SKC_KEYSTREAM_EN
    logic [15:0] lfsr_q;

    skc_lfsr u_lfsr (
        .C    (C),
        .R    (R),
        .load (start_take),
        .step (accept),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign exp_bit = key_sh[0] ^ lfsr_q[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign exp_bit     = key_sh[0];
`endif

    assign bit_mis = in_bit ^ exp_bit;

    always_ff @(posedge C) begin
        if (R) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            mismatch_q  <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= BUSY;
                        bit_count_q <= '0;
                        mismatch_q  <= 1'b0;
                        done_q      <= 1'b0;
                        ok_q        <= 1'b0;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        bit_count_q <= bit_count_d;
                        mismatch_q  <= mismatch_q | bit_mis;
                        // The final bit's compare folds straight into ok; start
                        // in this cycle is dropped because BUSY ignores it.
                        if (last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            ok_q    <= ~(mismatch_q | bit_mis);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_count = bit_count_q;
    assign done      = done_q;
    assign ok        = ok_q;

endmodule

// File: tb/tb_serial_key_checker.sv
// Self-checking bench for serial_key_checker. Expected ok values are queued
// when a key is driven and compared when done rises.
module tb_serial_key_checker;

    localparam logic [15:0] KEY  = 16'hD1CE;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       C = 1'b0;
    logic       R, start, in_valid, in_bit;
    logic       in_ready, done, ok;
    logic [4:0] bit_count;

    int n_cmp = 0;
    int n_mis = 0;
    bit exp_q[$];

    always #5 C = ~C;

    serial_key_checker #(
        .KEY_W     (16),
        .KEY       (KEY),
        .LFSR_SEED (SEED)
    ) dut (
        .C         (C),
        .R         (R),
        .start     (start),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .bit_count (bit_count),
        .done      (done),
        .ok        (ok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Bit pattern the checker should accept: KEY, xored with the keystream when enabled.
    function automatic logic [15:0] stream_key();
        logic [15:0] w;
        logic [15:0] l;
        logic        fb;
        w = KEY;
        l = SEED;
        fb = 1'b0;
`ifdef SKC_KEYSTREAM_EN
        for (int i = 0; i < 16; i++) begin
            w[i] = w[i] ^ l[0];
            fb   = l[0] ^ l[2] ^ l[3] ^ l[5];
            l    = {fb, l[15:1]};
        end
`endif
        return w;
    endfunction

    task automatic run_check(input logic [15:0] stim, input bit rnd, input bit mid_start,
                             input string tag);
        int  gaps;
        int  t;
        bit  e;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".ready"}, in_ready, 1);
        chk({tag, ".cnt0"}, bit_count, 0);
        chk({tag, ".done_clr"}, done, 0);
        chk({tag, ".ok_clr"}, ok, 0);
        exp_q.push_back(stim == stream_key());
        for (int i = 0; i < 16; i++) begin
            if (rnd) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom_range(0, 1));
                    start    = mid_start;
                    tick();
                    start    = 1'b0;
                    chk({tag, ".gap_cnt"}, bit_count, i);
                end
            end
            in_valid = 1'b1;
            in_bit   = stim[i];
            start    = mid_start && (i == 15);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            if (i < 15) begin
                if (bit_count !== 5'(i + 1) || done !== 1'b0)
                    chk({tag, ".progress"}, {bit_count, 3'b0, done}, {5'(i + 1), 4'b0});
            end
        end
        t = 0;
        while (done !== 1'b1 && t < 4) begin
            tick();
            t++;
        end
        if (done !== 1'b1) begin
            chk({tag, ".done_timeout"}, done, 1);
            void'(exp_q.pop_front());
        end else begin
            chk({tag, ".latency"}, t, 0);
            e = exp_q.pop_front();
            chk({tag, ".ok"}, ok, e);
            chk({tag, ".cnt16"}, bit_count, 16);
            chk({tag, ".not_ready"}, in_ready, 0);
        end
    endtask

    initial begin
        logic [15:0] good;
        good     = stream_key();
        R        = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;

        // T1: reset state, then in_valid in IDLE is ignored
        tick();
        tick();
        chk("t1.ready", in_ready, 0);
        chk("t1.done", done, 0);
        chk("t1.ok", ok, 0);
        chk("t1.cnt", bit_count, 0);
        R        = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t1.idle_cnt", bit_count, 0);
        chk("t1.idle_ready", in_ready, 0);
        chk("t1.idle_done", done, 0);

        // T2: correct key back-to-back
        run_check(good, 1'b0, 1'b0, "t2");

        // T3: bit 7 flipped, then correct key again
        run_check(good ^ 16'h0080, 1'b0, 1'b0, "t3bad");
        run_check(good, 1'b0, 1'b0, "t3good");
        // also a mismatch on the very last bit only
        run_check(good ^ 16'h8000, 1'b0, 1'b0, "t3last");
        run_check(good ^ 16'h0001, 1'b1, 1'b0, "t3first");

        // T4: random gaps, start during BUSY and with the last bit, in_valid held in DONE
        run_check(good, 1'b1, 1'b1, "t4");
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            tick();
            chk("t4.hold_done", done, 1);
            chk("t4.hold_ok", ok, 1);
            chk("t4.hold_cnt", bit_count, 16);
        end
        in_valid = 1'b0;

        // T5: reset after 9 bits discards the check
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_bit   = good[i];
            tick();
        end
        in_valid = 1'b0;
        chk("t5.cnt9", bit_count, 9);
        R = 1'b1;
        tick();
        R = 1'b0;
        chk("t5.rst_ready", in_ready, 0);
        chk("t5.rst_cnt", bit_count, 0);
        chk("t5.rst_done", done, 0);
        chk("t5.rst_ok", ok, 0);
        run_check(good, 1'b0, 1'b0, "t5");

`ifdef SKC_KEYSTREAM_EN
        // T6: raw KEY must fail once the keystream is applied
        run_check(KEY, 1'b0, 1'b0, "t6raw");
        run_check(good, 1'b1, 1'b0, "t6ks");
`endif

        chk("sb.empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
